// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone pipelined master.
// It turns a valid/ready command stream into one bus transaction per command
// and returns the result on a valid/ready response stream. A per-transaction
// timeout keeps a dead slave from hanging the command path.
module wb_cmd_master #(
  parameter int unsigned ADDR_W  = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_we,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_data,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_err,
  output logic              o_rsp_timeout,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic [DATA_W-1:0] o_wb_data,
  input  logic              i_wb_ack,
  input  logic              i_wb_stall,
  input  logic              i_wb_err,
  input  logic [DATA_W-1:0] i_wb_data
);

  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;
  logic              r_rsp_to;

  logic w_last;
  logic w_fin;
  logic w_err;
  logic w_to;
  logic w_cap;
  logic w_bus;

  assign w_last = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_bus  = (r_state == REQ) || (r_state == WAIT);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next state and termination decode; err beats ack, a real termination beats timeout.
  always_comb begin
    w_next = r_state;
    w_fin  = 1'b0;
    w_err  = 1'b0;
    w_to   = 1'b0;
    w_cap  = 1'b0;
    case (r_state)
      IDLE: if (i_cmd_valid) w_next = REQ;
      REQ: begin
        if (!i_wb_stall && (i_wb_err || i_wb_ack)) begin
          w_fin = 1'b1;
          w_err = i_wb_err;
          w_cap = !i_wb_err && !r_we;
        end else if (w_last) begin
          w_fin = 1'b1;
          w_err = 1'b1;
          w_to  = 1'b1;
        end else if (!i_wb_stall) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (i_wb_err || i_wb_ack) begin
          w_fin = 1'b1;
          w_err = i_wb_err;
          w_cap = !i_wb_err && !r_we;
        end else if (w_last) begin
          w_fin = 1'b1;
          w_err = 1'b1;
          w_to  = 1'b1;
        end
      end
      RESP: if (i_rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_fin) w_next = RESP;
  end

  // Command capture, timeout counter and response registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
      r_rsp_to   <= 1'b0;
    end else begin
      if (r_state == IDLE && i_cmd_valid) begin
        r_we   <= i_cmd_we;
        r_addr <= i_cmd_addr;
        r_data <= i_cmd_data;
        r_cnt  <= '0;
      end else if (w_bus) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fin) begin
        r_rsp_err  <= w_err;
        r_rsp_to   <= w_to;
        r_rsp_data <= w_cap ? i_wb_data : '0;
      end
    end
  end

  assign o_cmd_ready   = (r_state == IDLE);
  assign o_wb_cyc      = w_bus;
  assign o_wb_stb      = (r_state == REQ);
  assign o_wb_we       = w_bus && r_we;
  assign o_wb_addr     = w_bus ? r_addr : '0;
  assign o_wb_data     = w_bus ? r_data : '0;
  assign o_rsp_valid   = (r_state == RESP);
  assign o_rsp_data    = o_rsp_valid ? r_rsp_data : '0;
  assign o_rsp_err     = o_rsp_valid && r_rsp_err;
  assign o_rsp_timeout = o_rsp_valid && r_rsp_to;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master with a small configurable Wishbone slave.
module tb_wb_cmd_master;
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_ready;
  logic          i_cmd_we = 1'b0;
  logic [AW-1:0] i_cmd_addr = '0;
  logic [DW-1:0] i_cmd_data = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b0;
  logic [DW-1:0] o_rsp_data;
  logic          o_rsp_err;
  logic          o_rsp_timeout;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [DW-1:0] o_wb_data;
  logic          i_wb_ack;
  logic          i_wb_stall;
  logic          i_wb_err;
  logic [DW-1:0] i_wb_data;

  int checks = 0;
  int errors = 0;

  // Slave configuration: mode 0 = ack, 1 = err+ack together, 2 = never answer.
  int unsigned cfg_stall = 0;
  int unsigned cfg_delay = 0;
  int          cfg_mode  = 0;
  logic [DW-1:0] cfg_rdata = '0;

  int unsigned s_stall = 0;
  int unsigned s_wait  = 0;
  logic        s_acc   = 1'b0;
  logic        w_hit;

  always #5 clk = ~clk;

  wb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
    .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  // Slave sequencing: stall count, then ack cfg_delay cycles after acceptance.
  always @(posedge clk) begin
    if (!o_wb_cyc) begin
      s_stall <= cfg_stall;
      s_acc   <= 1'b0;
      s_wait  <= 0;
    end else if (o_wb_stb) begin
      if (s_stall != 0) s_stall <= s_stall - 1;
      else begin
        s_acc  <= 1'b1;
        s_wait <= (cfg_delay > 0) ? cfg_delay - 1 : 0;
      end
    end else if (s_wait != 0) begin
      s_wait <= s_wait - 1;
    end
  end

  // Slave answer, combinational from stb when the delay is zero.
  always_comb begin
    w_hit      = (o_wb_stb && s_stall == 0 && cfg_delay == 0) ||
                 (o_wb_cyc && !o_wb_stb && s_acc && s_wait == 0);
    i_wb_stall = o_wb_stb && (s_stall != 0);
    i_wb_ack   = w_hit && (cfg_mode != 2);
    i_wb_err   = w_hit && (cfg_mode == 1);
    i_wb_data  = cfg_rdata;
  end

  task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one command and follow it to the response; stops at the first rsp_valid cycle.
  task automatic run_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         output int lat, output int ncyc, output int nstb, output int bad);
    @(negedge clk);
    check_val("cmd_ready_before", {31'd0, o_cmd_ready}, 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_we    = we;
    i_cmd_addr  = addr;
    i_cmd_data  = data;
    @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    lat = 0; ncyc = 0; nstb = 0; bad = 0;
    for (int i = 0; i < 40; i++) begin
      lat++;
      if (o_rsp_valid) break;
      if (o_wb_cyc) ncyc++;
      if (o_wb_stb) begin
        nstb++;
        if (o_wb_addr !== addr || o_wb_we !== we || (we && o_wb_data !== data)) bad++;
      end
      @(negedge clk);
    end
  endtask

  // Consume the response, then confirm the master is idle again.
  task automatic take_rsp(input string tag);
    i_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check_val({tag, "_ready_after"}, {31'd0, o_cmd_ready}, 32'd1);
    check_val({tag, "_valid_after"}, {31'd0, o_rsp_valid}, 32'd0);
  endtask

  task automatic check_rsp(input string tag, input logic [DW-1:0] data, input logic err, input logic to);
    check_val({tag, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd1);
    check_val({tag, "_rsp_data"}, o_rsp_data, data);
    check_val({tag, "_rsp_err"}, {31'd0, o_rsp_err}, {31'd0, err});
    check_val({tag, "_rsp_to"}, {31'd0, o_rsp_timeout}, {31'd0, to});
    check_val({tag, "_cyc_in_rsp"}, {31'd0, o_wb_cyc}, 32'd0);
  endtask

  initial begin
    int lat, ncyc, nstb, bad;
    logic [DW-1:0] snap_d;
    logic snap_e, snap_t;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
    check_val("rst_cyc", {31'd0, o_wb_cyc}, 32'd0);
    check_val("rst_stb", {31'd0, o_wb_stb}, 32'd0);
    check_val("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    rst = 1'b0;

    // Write, no stall, combinational ack; read data must not leak into a write response.
    cfg_stall = 0; cfg_delay = 0; cfg_mode = 0; cfg_rdata = 32'hA5A5A5A5;
    run_cmd(1'b1, 2'd1, 32'h00000001, lat, ncyc, nstb, bad);
    check_val("wr_lat", lat, 2);
    check_val("wr_stb", nstb, 1);
    check_val("wr_cyc", ncyc, 1);
    check_val("wr_bus", bad, 0);
    check_rsp("wr", 32'h0, 1'b0, 1'b0);
    take_rsp("wr");

    // Read, 2 stall cycles then 3-cycle ack delay.
    cfg_stall = 2; cfg_delay = 3; cfg_rdata = 32'hDEADBEEF;
    run_cmd(1'b0, 2'd2, 32'h0, lat, ncyc, nstb, bad);
    check_val("rd_lat", lat, 7);
    check_val("rd_stb", nstb, 3);
    check_val("rd_cyc", ncyc, 6);
    check_val("rd_bus", bad, 0);
    check_rsp("rd", 32'hDEADBEEF, 1'b0, 1'b0);
    take_rsp("rd");

    // err and ack together on the first accepted cycle.
    cfg_stall = 0; cfg_delay = 0; cfg_mode = 1; cfg_rdata = 32'h11111111;
    run_cmd(1'b0, 2'd3, 32'h0, lat, ncyc, nstb, bad);
    check_val("err_lat", lat, 2);
    check_rsp("err", 32'h0, 1'b1, 1'b0);
    take_rsp("err");

    // Dead slave: timeout after exactly TO cycles of cyc.
    cfg_mode = 2; cfg_rdata = 32'h22222222;
    run_cmd(1'b0, 2'd0, 32'h0, lat, ncyc, nstb, bad);
    check_val("to_cyc", ncyc, TO);
    check_rsp("to", 32'h0, 1'b1, 1'b1);
    take_rsp("to");

    // Ack in the very last allowed cycle wins over the timeout.
    cfg_mode = 0; cfg_delay = TO - 1; cfg_rdata = 32'hCAFEF00D;
    run_cmd(1'b0, 2'd1, 32'h0, lat, ncyc, nstb, bad);
    check_val("edge_cyc", ncyc, TO);
    check_rsp("edge", 32'hCAFEF00D, 1'b0, 1'b0);
    take_rsp("edge");

    // Ack one cycle too late: timeout.
    cfg_delay = TO;
    run_cmd(1'b0, 2'd1, 32'h0, lat, ncyc, nstb, bad);
    check_val("late_cyc", ncyc, TO);
    check_rsp("late", 32'h0, 1'b1, 1'b1);
    take_rsp("late");

    // Backpressure: response held 5 cycles, no command accepted meanwhile.
    cfg_delay = 1; cfg_rdata = 32'h0BADF00D;
    run_cmd(1'b0, 2'd2, 32'h0, lat, ncyc, nstb, bad);
    check_rsp("bp", 32'h0BADF00D, 1'b0, 1'b0);
    snap_d = o_rsp_data; snap_e = o_rsp_err; snap_t = o_rsp_timeout;
    i_cmd_valid = 1'b1; i_cmd_we = 1'b1; i_cmd_addr = 2'd3; i_cmd_data = 32'h77;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!o_rsp_valid || o_rsp_data !== snap_d || o_rsp_err !== snap_e ||
          o_rsp_timeout !== snap_t || o_cmd_ready !== 1'b0 || o_wb_cyc !== 1'b0) bad++;
    end
    i_cmd_valid = 1'b0;
    check_val("bp_stable", bad, 0);
    take_rsp("bp");

    // Reset for one cycle while in WAIT.
    cfg_delay = 5;
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_we = 1'b0; i_cmd_addr = 2'd1;
    @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    @(negedge clk);
    check_val("mid_in_wait", {30'd0, o_wb_cyc, o_wb_stb}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid_cyc_stb", {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
    check_val("mid_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check_val("mid_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);

    // Following read completes normally.
    cfg_delay = 1; cfg_rdata = 32'h12345678;
    run_cmd(1'b0, 2'd2, 32'h0, lat, ncyc, nstb, bad);
    check_val("post_lat", lat, 3);
    check_val("post_cyc", ncyc, 2);
    check_rsp("post", 32'h12345678, 1'b0, 1'b0);
    take_rsp("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard bound on simulation time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Single-outstanding Wishbone pipelined bus master that turns a valid/ready command stream into one bus transaction per command, and returns a valid/ready response stream.
- Sits directly upstream of the register-mapped Wishbone slaves; for example, it drives the LED control slave from a host or debug command source.
- Handles stall, ack, err and a bus timeout, so a dead slave cannot hang the command path.

Parameters:
- ADDR_W, 2, Wishbone address width in bits.
- DATA_W, 32, Wishbone data width in bits.
- TIMEOUT, 255, max cycles o_wb_cyc stays high per transaction; 0 disables the timeout.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  master can accept a command.
- i_cmd_we  in  1  1 = write, 0 = read.
- i_cmd_addr  in  ADDR_W  target address.
- i_cmd_data  in  DATA_W  write data; ignored for reads.
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  consumer accepts the response.
- o_rsp_data  out  DATA_W  read data; 0 for writes and for failed transactions.
- o_rsp_err  out  1  transaction terminated by i_wb_err or timeout.
- o_rsp_timeout  out  1  transaction terminated by timeout.
- o_wb_cyc  out  1  Wishbone cycle.
- o_wb_stb  out  1  Wishbone strobe.
- o_wb_we  out  1  Wishbone write enable.
- o_wb_addr  out  ADDR_W  Wishbone address.
- o_wb_data  out  DATA_W  Wishbone write data.
- i_wb_ack  in  1  slave acknowledge; may be combinational from stb.
- i_wb_stall  in  1  slave stall.
- i_wb_err  in  1  slave error.
- i_wb_data  in  DATA_W  slave read data.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - All outputs go to 0, except o_cmd_ready = 1 in IDLE.
  - Timeout counter clears.
  - Reset mid-transaction: o_wb_cyc/o_wb_stb drop at the next edge; no response is issued.
- FSM has four states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - o_cmd_ready = 1; all bus outputs 0.
  - On i_cmd_valid && o_cmd_ready: register we/addr/data, clear the counter, go to REQ.
- REQ:
  - o_wb_cyc = o_wb_stb = 1; we/addr/data come from the registers.
  - Strobe is accepted in a cycle where i_wb_stall = 0.
  - If accepted and i_wb_err: go to RESP, err = 1.
  - Else if accepted and i_wb_ack: capture i_wb_data (reads only), go to RESP.
  - Else if accepted: go to WAIT.
  - Ack/err while i_wb_stall = 1 are ignored.
- WAIT:
  - o_wb_cyc = 1, o_wb_stb = 0.
  - i_wb_err → RESP with err = 1.
  - Else i_wb_ack → capture read data, go to RESP.
- Precedence: err beats ack when both are high in the same cycle; o_rsp_data is then 0.
- Timeout:
  - Counter increments every cycle in REQ and WAIT.
  - If the cycle with counter == TIMEOUT-1 ends without termination, go to RESP with err = 1, timeout = 1, data = 0.
  - o_wb_cyc is therefore high for exactly TIMEOUT cycles.
  - A termination in that same last cycle takes priority over the timeout.
- RESP:
  - Bus outputs are 0; o_rsp_valid = 1; data/err/timeout are held stable.
  - On i_rsp_ready: go to IDLE.
- Flags: o_rsp_err and o_rsp_timeout are valid only while o_rsp_valid; they are 0 otherwise.
- Ready rule: o_cmd_ready is 1 only in IDLE, so there is at most one outstanding transaction. No command is accepted in the cycle a response is consumed; the next acceptance is the following cycle.
- Latency: command accepted at edge N → stb high in cycle N+1 → with no stall and combinational ack, o_rsp_valid in cycle N+2. Each stall cycle and each ack-wait cycle adds 1.
- Bus outputs never change while o_wb_stb = 1 && i_wb_stall = 1.

Test Plan:
- Write, no stall, combinational ack: cmd we=1 addr=1 data=0x00000001 → stb for 1 cycle with addr=1, we=1, data=1; rsp_valid 2 cycles after accept; err=0, rsp_data=0.
- Read with 2 stall cycles then 3-cycle ack delay, slave data 0xDEADBEEF → stb high 3 cycles with stable addr; cyc high 6 cycles; rsp_data=0xDEADBEEF, err=0.
- Error: slave asserts err and ack together on the first accepted cycle → rsp err=1, timeout=0, data=0; cyc low the next cycle.
- Timeout with TIMEOUT=8 and a slave that never acks → cyc high exactly 8 cycles; rsp err=1, timeout=1; next command accepted after rsp handshake.
- Backpressure: i_rsp_ready held low 5 cycles → rsp fields stable, cmd_ready=0 throughout; after ready, cmd_ready=1 the next cycle.
- Reset asserted for 1 cycle during WAIT → cyc/stb/rsp_valid 0 at the next edge; cmd_ready=1; the following read completes normally.
